// File: rtl/spi_cfg_if.sv
// Configuration-port bundle between a controller, spi_cfg_master and the radio's SPI receiver.
// The master modport is the transmitter's view; the slave modport is the controller/receiver view.
interface spi_cfg_if;
  logic        start;
  logic [15:0] phase_inc_in;
  logic [2:0]  gain_in;
  logic        busy;
  logic        done;
  logic        CS;
  logic        SCK;
  logic        MOSI;

  modport master (
    input  start, phase_inc_in, gain_in,
    output busy, done, CS, SCK, MOSI
  );

  modport slave (
    output start, phase_inc_in, gain_in,
    input  busy, done, CS, SCK, MOSI
  );
endinterface

// File: rtl/spi_cfg_master.sv
// Write-only SPI mode-0 transmitter: one 24-bit frame {5'b0, gain, phase_inc}, MSB first.
// Optional SPI_CFG_AUTO_SEND_EN: resend automatically whenever the inputs differ from the last frame sent.
module spi_cfg_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic         CLK,
  input  logic         RSTb,
  spi_cfg_if.master    bus
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_cnt;
  logic [23:0]   shreg;
  logic          cs_q, sck_q, busy_q, done_q;

  logic          div_end, gap_end, go, accept;
  logic [23:0]   frame_word;

  assign frame_word = {5'b0, bus.gain_in, bus.phase_inc_in};
  assign div_end    = (cnt == CW'(CLK_DIV - 1));
  assign gap_end    = (state == GAP) && (cnt == CW'(CS_GAP - 1));

`ifdef SPI_CFG_AUTO_SEND_EN
  // Shadow of the last frame sent; its reset value mirrors the receiver's reset contents.
  logic [18:0] last_sent;

  assign go = bus.start || ({bus.gain_in, bus.phase_inc_in} != last_sent);

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb)       last_sent <= 19'h30987;
    else if (accept) last_sent <= {bus.gain_in, bus.phase_inc_in};
  end
`else
  assign go = bus.start;
`endif

  // A request at the end of the gap is taken on the same edge that raises done.
  assign accept = go && ((state == IDLE) || gap_end);

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= gap_end;
      if (accept) begin
        shreg   <= frame_word;
        bit_cnt <= 5'd23;
        cnt     <= '0;
        cs_q    <= 1'b0;
        sck_q   <= 1'b0;
        busy_q  <= 1'b1;
        state   <= SETUP;
      end else begin
        case (state)
          IDLE: cnt <= '0;
          SETUP, LOW: begin
            if (div_end) begin
              cnt   <= '0;
              sck_q <= 1'b1;
              state <= HIGH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HIGH: begin
            if (div_end) begin
              cnt   <= '0;
              sck_q <= 1'b0;
              // Next bit appears on the falling edge, giving a full half-period of setup.
              if (bit_cnt != 5'd0) begin
                shreg   <= {shreg[22:0], 1'b0};
                bit_cnt <= bit_cnt - 5'd1;
                state   <= LOW;
              end else begin
                state <= HOLD;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HOLD: begin
            if (div_end) begin
              cnt   <= '0;
              cs_q  <= 1'b1;
              state <= GAP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (gap_end) begin
              cnt    <= '0;
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.CS   = cs_q;
  assign bus.SCK  = sck_q;
  assign bus.MOSI = shreg[23];
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
